// File: rtl/wave_chk_pkg.sv
// Shared types and defaults for the waveform pattern checker.
// The checker and its rotation matcher both import this package.
package wave_chk_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HUNT = 2'd1,
      LOCK = 2'd2
   } state_t;

   localparam int DEF_PAT_LEN  = 5;
   localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b01010;
   localparam int DEF_MISS_MAX = 3;
   localparam int DEF_CNT_W    = 16;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int count_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/wave_rot_match.sv
// Finds the lowest rotation of PATTERN that equals the sample window.
// Window bit j is the j-th oldest sample; rotation r means window[j] == PATTERN[(r+j) % PAT_LEN].
module wave_rot_match
   import wave_chk_pkg::*;
#(
   parameter int PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   parameter int PH_W = $clog2(PAT_LEN)
) (
   input  logic [PAT_LEN-1:0] window,
   output logic               hit,
   output logic [PH_W-1:0]    rot
);

   logic [PAT_LEN-1:0] match_vec;

   for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_rot
      logic [PAT_LEN-1:0] rot_pat;
      for (genvar gj = 0; gj < PAT_LEN; gj++) begin : g_bit
         assign rot_pat[gj] = PATTERN[(gi + gj) % PAT_LEN];
      end
      assign match_vec[gi] = (window == rot_pat);
   end

   // Scan downward so the lowest matching rotation is the one that sticks.
   always_comb begin
      hit = |match_vec;
      rot = '0;
      for (int i = PAT_LEN - 1; i >= 0; i--) begin
         if (match_vec[i]) begin
            rot = PH_W'(i);
         end
      end
   end

endmodule

// File: rtl/wave_pattern_checker.sv
// Locks to a repeating serial pattern at any phase, then scores every valid bit.
// Also watches the companion toggle wave for missed transitions.
module wave_pattern_checker
   import wave_chk_pkg::*;
#(
   parameter int PAT_LEN  = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   parameter int MISS_MAX = DEF_MISS_MAX,
   parameter int CNT_W    = DEF_CNT_W,
   localparam int PH_W    = $clog2(PAT_LEN)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             data_in,
   input  logic             clk_wave_in,
   input  logic             clr_cnt,
   output logic             locked,
   output logic [PH_W-1:0]  phase,
   output logic             err_pulse,
   output logic [CNT_W-1:0] good_count,
   output logic [CNT_W-1:0] err_count,
   output logic             clk_err
);

   localparam int MISS_W = count_width(MISS_MAX);
   localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(PAT_LEN - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t             state_reg, state_next;
   logic [PAT_LEN-1:0] window_reg, window_shift;
   logic [PH_W-1:0]    fill_reg, fill_next;
   logic [PH_W-1:0]    phase_reg, phase_next;
   logic [MISS_W-1:0]  miss_reg, miss_next;
   logic [CNT_W-1:0]   good_reg, err_reg;
   logic               err_pulse_reg, clk_err_reg;
   logic               wave_prev_reg, wave_seen_reg;

   logic               hit;
   logic [PH_W-1:0]    rot;
   logic               bit_good, bit_bad;
   logic               wave_fail;

   // Newest sample enters at the MSB; the match always looks at the post-shift window.
   assign window_shift = {data_in, window_reg[PAT_LEN-1:1]};

   wave_rot_match #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .PH_W    (PH_W)
   ) u_rot_match (
      .window (window_shift),
      .hit    (hit),
      .rot    (rot)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= FILL;
         fill_reg  <= '0;
         phase_reg <= '0;
         miss_reg  <= '0;
      end else begin
         state_reg <= state_next;
         fill_reg  <= fill_next;
         phase_reg <= phase_next;
         miss_reg  <= miss_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      fill_next  = fill_reg;
      phase_next = phase_reg;
      miss_next  = miss_reg;
      bit_good   = 1'b0;
      bit_bad    = 1'b0;
      if (valid_in) begin
         unique case (state_reg)
            FILL: begin
               if (fill_reg == LAST_PH) begin
                  if (hit) begin
                     state_next = LOCK;
                     phase_next = rot;
                     miss_next  = '0;
                  end else begin
                     state_next = HUNT;
                  end
               end else begin
                  fill_next = fill_reg + PH_W'(1);
               end
            end
            HUNT: begin
               if (hit) begin
                  state_next = LOCK;
                  phase_next = rot;
                  miss_next  = '0;
               end
            end
            LOCK: begin
               phase_next = (phase_reg == LAST_PH) ? '0 : phase_reg + PH_W'(1);
               if (data_in == PATTERN[phase_reg]) begin
                  bit_good  = 1'b1;
                  miss_next = '0;
               end else begin
                  bit_bad = 1'b1;
                  if (miss_reg == MISS_LAST) begin
                     state_next = HUNT;
                     phase_next = '0;
                     miss_next  = '0;
                  end else begin
                     miss_next = miss_reg + MISS_W'(1);
                  end
               end
            end
            default: begin
               state_next = FILL;
               fill_next  = '0;
               phase_next = '0;
               miss_next  = '0;
            end
         endcase
      end
   end

   always_comb begin
      locked = (state_reg == LOCK);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         window_reg <= '0;
      end else if (valid_in) begin
         window_reg <= window_shift;
      end
   end

   // The first valid sample after reset only seeds the history.
   assign wave_fail = valid_in && wave_seen_reg && (clk_wave_in == wave_prev_reg);

   always_ff @(posedge clock) begin
      if (reset) begin
         good_reg      <= '0;
         err_reg       <= '0;
         err_pulse_reg <= 1'b0;
         clk_err_reg   <= 1'b0;
         wave_prev_reg <= 1'b0;
         wave_seen_reg <= 1'b0;
      end else begin
         err_pulse_reg <= bit_bad;
         if (clr_cnt) begin
            good_reg    <= '0;
            err_reg     <= '0;
            clk_err_reg <= 1'b0;
         end else begin
            if (bit_good && (good_reg != CNT_MAX)) begin
               good_reg <= good_reg + CNT_W'(1);
            end
            if (bit_bad && (err_reg != CNT_MAX)) begin
               err_reg <= err_reg + CNT_W'(1);
            end
            if (wave_fail) begin
               clk_err_reg <= 1'b1;
            end
         end
         if (valid_in) begin
            wave_prev_reg <= clk_wave_in;
            wave_seen_reg <= 1'b1;
         end
      end
   end

   assign phase      = phase_reg;
   assign err_pulse  = err_pulse_reg;
   assign good_count = good_reg;
   assign err_count  = err_reg;
   assign clk_err    = clk_err_reg;

endmodule
